spi_addr_master: RTL and testbench
==================================

SPI_ADDR_MASTER -- requirements
Module: spi_addr_master

Interface
REQ-001 Parameters SHALL be: CLKDIV, default 2, clock cycles per sck half-period, minimum 1; RD_LAT, default 1, read-latency words; TAIL_CLKS, default 1, extra sck pulses before cs deasserts.
REQ-002 clock  in  1  system clock; all logic rises on posedge clock.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  one-cycle transaction request; sampled only while busy=0.
REQ-005 rd, wr, autoinc  in  1 each  command bits 15, 14, 13.
REQ-006 addr  in  13  register address, command bits 12:0.
REQ-007 count  in  8  number of data words, 0..255; 0 = command word only.
REQ-008 wdata  in  16  write data word; consumed on wdata_ack.
REQ-009 wdata_ack  out  1  one-cycle pulse when wdata is loaded into the shifter.
REQ-010 rdata  out  16  captured read word; valid on rdata_valid.
REQ-011 rdata_valid  out  1  one-cycle pulse per delivered read word.
REQ-012 busy  out  1  high from the cycle after an accepted start until the GAP state ends.
REQ-013 done  out  1  one-cycle pulse when cs deasserts.
REQ-014 sck, mosi, cs  out  1 each  SPI master outputs, CPOL=0/CPHA=0; cs active-low.
REQ-015 miso  in  1  SPI data from the slave.

Function
REQ-016 start with busy=0 SHALL latch rd, wr, autoinc, addr and count; start with busy=1 SHALL be ignored.
REQ-017 Command word SHALL be {rd, wr, autoinc, addr}, shifted MSB first.
REQ-018 Data slots SHALL number count+RD_LAT when rd=1, otherwise count.
REQ-019 States: IDLE -> CS_SETUP (cs=0, one half-period) -> SHIFT (16 sck cycles per word, all words back-to-back with no sck gap) -> TAIL (TAIL_CLKS sck pulses, mosi=0) -> CS_HOLD (one half-period, sck=0) -> GAP (cs=1, two half-periods) -> IDLE.
REQ-020 mosi SHALL change only on sck falling edges or in CS_SETUP; miso SHALL be sampled in the clock cycle that drives sck rising.
REQ-021 At each data-slot load with wr=1 and slot index < count, the shifter SHALL take wdata and pulse wdata_ack; all other slots SHALL shift 0x0000 with no ack.
REQ-022 The host SHALL update wdata within 16 half-periods of wdata_ack; wdata_ack for slot n+1 SHALL occur 32*CLKDIV cycles after the ack for slot n.
REQ-023 With rd=1, captured words of data slots 0..RD_LAT-1 SHALL be discarded; the following count words SHALL each pulse rdata_valid one cycle after their 16th miso sample.
REQ-024 rd=1 and wr=1 together SHALL be legal: write words shifted out and read words captured in the same slots.
REQ-025 With count=0 and rd=0, exactly 16+TAIL_CLKS sck pulses SHALL occur and no wdata_ack or rdata_valid SHALL be produced.
REQ-026 A counter of at least 9 bits SHALL track slots so that count=255 with RD_LAT=1 gives 256 data slots without wrap.
REQ-027 done SHALL pulse in the cycle cs goes high; busy SHALL fall when GAP ends.

Reset
REQ-028 reset_n=0 SHALL force, asynchronously, the following: state IDLE, cs=1, sck=0, mosi=0, busy=0, done=0, wdata_ack=0, rdata_valid=0, rdata=0x0000.
REQ-029 Reset during a transaction SHALL abort it with no done pulse, and the next start after release SHALL run a complete transaction.

Verification
REQ-030 Write with wr=1, autoinc=1, addr=0x0123, count=2, wdata 0xA5A5 then 0x5A5A SHALL give mosi words 0x6123, 0xA5A5, 0x5A5A, 2 wdata_ack, 48+1 sck pulses, 1 done.
REQ-031 Read with rd=1, addr=0x1FFF, count=1 and a slave model returning 0xBEEF in slot 1 SHALL give mosi 0x9FFF, 0x0000, 0x0000, exactly one rdata_valid with rdata=0xBEEF, and 49 sck pulses.
REQ-032 CLKDIV=1 and CLKDIV=5 SHALL give sck periods of 2 and 10 clocks, with cs-fall to first sck rise and last sck fall to cs-rise both equal to CLKDIV.
REQ-033 start pulsed again while busy=1 SHALL be ignored: one cs frame, one done.
REQ-034 reset_n low mid-word SHALL give cs=1, sck=0 in the same cycle with no done, and a following write of count=0 SHALL give 17 sck pulses and mosi 0x4000 for wr=1, addr=0.
REQ-035 count=255, rd=1 SHALL give 255 rdata_valid pulses and 257*16+1 sck pulses.

Source files
------------

// File: rtl/spi_addr_master.sv
`timescale 1ns/1ps
// SPI register-access master (CPOL=0/CPHA=0).
// Sends a 16-bit command word {rd, wr, autoinc, addr} followed by back-to-back
// 16-bit data slots, then a short sck tail, cs hold and inter-frame gap.
module spi_addr_master #(
   parameter int CLKDIV    = 2,   // clocks per sck half-period (>= 1)
   parameter int RD_LAT    = 1,   // leading read slots discarded
   parameter int TAIL_CLKS = 1    // extra sck pulses before cs rises
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic        rd,
   input  logic        wr,
   input  logic        autoinc,
   input  logic [12:0] addr,
   input  logic [7:0]  count,
   input  logic [15:0] wdata,
   output logic        wdata_ack,
   output logic [15:0] rdata,
   output logic        rdata_valid,
   output logic        busy,
   output logic        done,
   output logic        sck,
   output logic        mosi,
   output logic        cs,
   input  logic        miso
);

   localparam int              DW        = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
   localparam logic [DW-1:0]   DIV_LAST  = DW'(CLKDIV - 1);
   // Word index covers command word plus up to 255+RD_LAT data slots.
   localparam int              SW        = 10;
   localparam logic [SW-1:0]   RDL       = SW'(RD_LAT);
   localparam logic [7:0]      TAIL_LAST = 8'((TAIL_CLKS > 0) ? TAIL_CLKS - 1 : 0);

   typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, TAIL, CS_HOLD, GAP} state_t;

   state_t          state, state_nxt;
   logic [DW-1:0]   div_cnt;
   logic [3:0]      bit_cnt;
   logic [SW-1:0]   word_idx;
   logic [SW-1:0]   nslots;
   logic [7:0]      tail_cnt;
   logic [7:0]      cnt_q;
   logic            rd_q, wr_q;
   logic [15:0]     sh, rx;
   logic            gap_half;
   logic            tick, rise, fall, sample, deliver, word_end, more, wslot;

   // Half-period strobe and sck edge decode.
   assign tick     = (state != IDLE) && (div_cnt == DIV_LAST);
   assign rise     = tick && !sck && (state inside {CS_SETUP, SHIFT, TAIL});
   assign fall     = tick &&  sck && (state inside {SHIFT, TAIL});
   assign sample   = rise && (state != TAIL);
   assign word_end = fall && (state == SHIFT) && (bit_cnt == 4'hF);
   // Word 0 is the command; word k carries data slot k-1.
   assign nslots   = {2'b00, cnt_q} + (rd_q ? RDL : '0);
   assign more     = word_idx < nslots;
   // Slot being loaded next has index word_idx.
   assign wslot    = wr_q && (word_idx < {2'b00, cnt_q});
   assign deliver  = sample && rd_q && (bit_cnt == 4'hF) && (word_idx > RDL);

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:     if (start)                           state_nxt = CS_SETUP;
         CS_SETUP: if (tick)                            state_nxt = SHIFT;
         SHIFT:    if (word_end && !more)               state_nxt = (TAIL_CLKS > 0) ? TAIL : CS_HOLD;
         TAIL:     if (fall && tail_cnt == TAIL_LAST)   state_nxt = CS_HOLD;
         CS_HOLD:  if (tick)                            state_nxt = GAP;
         GAP:      if (tick && gap_half)                state_nxt = IDLE;
         default:                                       state_nxt = IDLE;
      endcase
   end

   // Datapath: divider, shifters, counters and registered SPI/host outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt     <= '0;
         bit_cnt     <= '0;
         word_idx    <= '0;
         tail_cnt    <= '0;
         cnt_q       <= '0;
         rd_q        <= 1'b0;
         wr_q        <= 1'b0;
         sh          <= '0;
         rx          <= '0;
         gap_half    <= 1'b0;
         cs          <= 1'b1;
         sck         <= 1'b0;
         mosi        <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         wdata_ack   <= 1'b0;
         rdata_valid <= 1'b0;
         rdata       <= '0;
      end else begin
         done        <= 1'b0;
         wdata_ack   <= 1'b0;
         rdata_valid <= 1'b0;

         if (state == IDLE || tick) div_cnt <= '0;
         else                       div_cnt <= div_cnt + 1'b1;

         if (state == IDLE && start) begin
            rd_q     <= rd;
            wr_q     <= wr;
            cnt_q    <= count;
            sh       <= {rd, wr, autoinc, addr};
            mosi     <= rd;
            cs       <= 1'b0;
            busy     <= 1'b1;
            word_idx <= '0;
            bit_cnt  <= '0;
            tail_cnt <= '0;
            gap_half <= 1'b0;
         end

         if (rise) sck <= 1'b1;
         if (sample) rx <= {rx[14:0], miso};
         if (deliver) begin
            rdata       <= {rx[14:0], miso};
            rdata_valid <= 1'b1;
         end

         if (fall) begin
            sck <= 1'b0;
            if (state == TAIL) begin
               tail_cnt <= tail_cnt + 1'b1;
            end else if (bit_cnt == 4'hF) begin
               bit_cnt <= '0;
               if (more) begin
                  word_idx <= word_idx + 1'b1;
                  if (wslot) begin
                     sh        <= wdata;
                     mosi      <= wdata[15];
                     wdata_ack <= 1'b1;
                  end else begin
                     sh   <= '0;
                     mosi <= 1'b0;
                  end
               end else begin
                  mosi <= 1'b0;
               end
            end else begin
               bit_cnt <= bit_cnt + 1'b1;
               sh      <= {sh[14:0], 1'b0};
               mosi    <= sh[14];
            end
         end

         if (state == CS_HOLD && tick) begin
            cs   <= 1'b1;
            done <= 1'b1;
         end

         if (state == GAP && tick) begin
            gap_half <= 1'b1;
            if (gap_half) busy <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_spi_addr_master.sv
`timescale 1ns/1ps
// Scoreboard bench for spi_addr_master: stimulus pushes expected mosi words,
// read words and per-frame totals; monitors pop and compare as the DUT emits.
module tb_spi_addr_master;

   logic        clock = 1'b0, reset_n = 1'b0, start = 1'b0, start_t = 1'b0;
   logic        rd = 1'b0, wr = 1'b0, autoinc = 1'b0, miso = 1'b0;
   logic [12:0] addr = '0;
   logic [7:0]  count = '0;
   logic [15:0] wdata = '0;
   logic        wdata_ack, rdata_valid, busy, done, sck, mosi, cs;
   logic [15:0] rdata;

   // Timing-only instances (CLKDIV 1 and 5), index 1 and 2.
   logic [2:1]  t_ack, t_rv, t_busy, t_done, t_sck, t_mosi, t_cs;
   logic [15:0] t_rdata [2:1];

   always #5 clock = ~clock;

   spi_addr_master #(.CLKDIV(2), .RD_LAT(1), .TAIL_CLKS(1)) u0 (
      .clock(clock), .reset_n(reset_n), .start(start), .rd(rd), .wr(wr),
      .autoinc(autoinc), .addr(addr), .count(count), .wdata(wdata),
      .wdata_ack(wdata_ack), .rdata(rdata), .rdata_valid(rdata_valid),
      .busy(busy), .done(done), .sck(sck), .mosi(mosi), .cs(cs), .miso(miso));

   spi_addr_master #(.CLKDIV(1)) u1 (
      .clock(clock), .reset_n(reset_n), .start(start_t), .rd(rd), .wr(wr),
      .autoinc(autoinc), .addr(addr), .count(count), .wdata(wdata),
      .wdata_ack(t_ack[1]), .rdata(t_rdata[1]), .rdata_valid(t_rv[1]),
      .busy(t_busy[1]), .done(t_done[1]), .sck(t_sck[1]), .mosi(t_mosi[1]),
      .cs(t_cs[1]), .miso(1'b0));

   spi_addr_master #(.CLKDIV(5)) u5 (
      .clock(clock), .reset_n(reset_n), .start(start_t), .rd(rd), .wr(wr),
      .autoinc(autoinc), .addr(addr), .count(count), .wdata(wdata),
      .wdata_ack(t_ack[2]), .rdata(t_rdata[2]), .rdata_valid(t_rv[2]),
      .busy(t_busy[2]), .done(t_done[2]), .sck(t_sck[2]), .mosi(t_mosi[2]),
      .cs(t_cs[2]), .miso(1'b0));

   int checks = 0, errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic unexpected(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: DUT output with no expectation queued", nm);
   endtask

   typedef struct { int sckp; int acks; int rvs; } frame_t;

   logic [15:0] exp_mosi[$], exp_rdata[$], sq[$], wbuf[$];
   frame_t      exp_frame[$];
   int          frames_exp = 0, frames_seen = 0;

   // Host side of wdata: advance to the next queued word on each ack.
   int wptr = 0;
   always @(negedge clock) begin
      if (wdata_ack) wptr++;
      wdata = (wptr < wbuf.size()) ? wbuf[wptr] : 16'h0000;
   end

   // Slave model plus output monitor for u0.
   int          nb = 0, sckc = 0, ackc = 0, rvc = 0, sbit = 0;
   logic        psck = 1'b0, pcs0 = 1'b1;
   logic [15:0] mw = '0, sreg = '0;
   frame_t      ef;
   always @(negedge clock) begin
      if (!reset_n) begin
         nb = 0; sckc = 0; ackc = 0; rvc = 0; sbit = 0;
         sreg = '0; miso = 1'b0; psck = 1'b0; pcs0 = 1'b1;
      end else begin
         if (pcs0 && !cs) begin
            nb = 0; sckc = 0; ackc = 0; rvc = 0; sbit = 0;
            sreg = (sq.size() > 0) ? sq.pop_front() : 16'h0000;
            miso = sreg[15];
         end
         if (!pcs0 && cs) frames_seen++;
         if (!psck && sck) begin
            sckc++;
            mw = {mw[14:0], mosi};
            nb++;
            if (nb == 16) begin
               nb = 0;
               if (exp_mosi.size() == 0) unexpected("mosi word");
               else chk("mosi word", {16'h0, mw}, {16'h0, exp_mosi.pop_front()});
            end
         end
         if (psck && !sck) begin
            sbit++;
            if (sbit == 16) begin
               sbit = 0;
               sreg = (sq.size() > 0) ? sq.pop_front() : 16'h0000;
            end else begin
               sreg = {sreg[14:0], 1'b0};
            end
            miso = sreg[15];
         end
         if (wdata_ack) ackc++;
         if (rdata_valid) begin
            rvc++;
            if (exp_rdata.size() == 0) unexpected("rdata");
            else chk("rdata", {16'h0, rdata}, {16'h0, exp_rdata.pop_front()});
         end
         if (done) begin
            if (exp_frame.size() == 0) unexpected("done");
            else begin
               ef = exp_frame.pop_front();
               chk("cs high at done", {31'h0, cs}, 32'h1);
               chk("frame sck pulses", sckc, ef.sckp);
               chk("frame wdata_ack", ackc, ef.acks);
               chk("frame rdata_valid", rvc, ef.rvs);
            end
         end
         psck = sck;
         pcs0 = cs;
      end
   end

   // sck timing monitor across the three instances.
   int       cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;
   logic [2:0] tsck, tcs;
   assign tsck = {t_sck[2], t_sck[1], sck};
   assign tcs  = {t_cs[2],  t_cs[1],  cs};
   int   t_csf[3], t_rise[3], t_fall[3], setup[3], pmin[3], pmax[3], tiss[3], tdone[3];
   bit   fst[3];
   logic [2:0] tps = '0, tpc = '1;
   function automatic int div_of(input int i);
      return (i == 0) ? 2 : (i == 1) ? 1 : 5;
   endfunction
   always @(negedge clock) begin
      for (int i = 0; i < 3; i++) begin
         if (reset_n) begin
            if (tpc[i] && !tcs[i]) begin
               t_csf[i] = cyc; fst[i] = 1'b1; pmin[i] = 1000000; pmax[i] = 0;
            end
            if (!tps[i] && tsck[i]) begin
               if (fst[i]) begin
                  setup[i] = cyc - t_csf[i];
                  fst[i] = 1'b0;
               end else begin
                  if (cyc - t_rise[i] < pmin[i]) pmin[i] = cyc - t_rise[i];
                  if (cyc - t_rise[i] > pmax[i]) pmax[i] = cyc - t_rise[i];
               end
               t_rise[i] = cyc;
            end
            if (tps[i] && !tsck[i]) t_fall[i] = cyc;
            if (!tpc[i] && tcs[i] && tdone[i] < tiss[i]) begin
               chk($sformatf("div%0d cs-to-sck", div_of(i)), setup[i], div_of(i));
               chk($sformatf("div%0d min period", div_of(i)), pmin[i], 2 * div_of(i));
               chk($sformatf("div%0d max period", div_of(i)), pmax[i], 2 * div_of(i));
               chk($sformatf("div%0d sck-to-cs", div_of(i)), cyc - t_fall[i], div_of(i));
               tdone[i]++;
            end
         end
         tps[i] = tsck[i];
         tpc[i] = tcs[i];
      end
   end

   task automatic pulse_start();
      @(negedge clock); start = 1'b1;
      @(negedge clock); start = 1'b0;
   endtask

   task automatic issue(input bit r, input bit w, input bit ai, input logic [12:0] a,
                        input logic [7:0] c, input int s, input int ak, input int rv);
      frame_t f;
      f = '{s, ak, rv};
      exp_frame.push_back(f);
      frames_exp++;
      rd = r; wr = w; autoinc = ai; addr = a; count = c;
      @(negedge clock);
      pulse_start();
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      repeat (3) @(negedge clock);
      while (busy && n < 40000) begin @(negedge clock); n++; end
      if (busy) begin
         checks++; errors++;
         $display("FAIL %s: busy still high after %0d cycles", nm, n);
      end
      repeat (2) @(negedge clock);
   endtask

   logic [15:0] v;
   initial begin
      // Reset values.
      repeat (3) @(negedge clock);
      chk("rst cs", {31'h0, cs}, 32'h1);
      chk("rst sck", {31'h0, sck}, 32'h0);
      chk("rst mosi", {31'h0, mosi}, 32'h0);
      chk("rst busy", {31'h0, busy}, 32'h0);
      chk("rst done", {31'h0, done}, 32'h0);
      chk("rst wdata_ack", {31'h0, wdata_ack}, 32'h0);
      chk("rst rdata_valid", {31'h0, rdata_valid}, 32'h0);
      chk("rst rdata", {16'h0, rdata}, 32'h0);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      // Write, autoinc, two data words.
      exp_mosi.push_back(16'h6123); exp_mosi.push_back(16'hA5A5); exp_mosi.push_back(16'h5A5A);
      wbuf.push_back(16'hA5A5); wbuf.push_back(16'h5A5A);
      issue(0, 1, 1, 13'h0123, 8'd2, 49, 2, 0);
      wait_idle("write2");

      // Read one word, slot 0 discarded.
      exp_mosi.push_back(16'h9FFF); exp_mosi.push_back(16'h0000); exp_mosi.push_back(16'h0000);
      sq.push_back(16'h1111); sq.push_back(16'hDEAD); sq.push_back(16'hBEEF);
      exp_rdata.push_back(16'hBEEF);
      issue(1, 0, 0, 13'h1FFF, 8'd1, 49, 0, 1);
      wait_idle("read1");

      // Command only, also timed on u0.
      exp_mosi.push_back(16'h2AAA);
      tiss[0]++;
      issue(0, 0, 1, 13'h0AAA, 8'd0, 17, 0, 0);
      wait_idle("cmd only");

      // Simultaneous read and write.
      exp_mosi.push_back(16'hC055); exp_mosi.push_back(16'h1234);
      exp_mosi.push_back(16'h5678); exp_mosi.push_back(16'h0000);
      wbuf.push_back(16'h1234); wbuf.push_back(16'h5678);
      sq.push_back(16'h0000); sq.push_back(16'hAAAA); sq.push_back(16'h0F0F); sq.push_back(16'hF00F);
      exp_rdata.push_back(16'h0F0F); exp_rdata.push_back(16'hF00F);
      issue(1, 1, 0, 13'h0055, 8'd2, 65, 2, 2);
      wait_idle("rd+wr");

      // Second start while busy must be ignored.
      exp_mosi.push_back(16'h4001);
      issue(0, 1, 0, 13'h0001, 8'd0, 17, 0, 0);
      repeat (10) @(negedge clock);
      rd = 1'b1; addr = 13'h1FFF; count = 8'd3;
      pulse_start();
      wait_idle("start while busy");

      // Abort a read mid command word.
      rd = 1'b1; wr = 1'b0; addr = 13'h0777; count = 8'd1;
      pulse_start();
      repeat (30) @(negedge clock);
      #2 reset_n = 1'b0;
      #1;
      chk("abort cs", {31'h0, cs}, 32'h1);
      chk("abort sck", {31'h0, sck}, 32'h0);
      chk("abort done", {31'h0, done}, 32'h0);
      chk("abort busy", {31'h0, busy}, 32'h0);
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);
      exp_mosi.push_back(16'h4000);
      issue(0, 1, 0, 13'h0000, 8'd0, 17, 0, 0);
      wait_idle("after abort");

      // Longest read: 255 words, 257 words on the wire.
      exp_mosi.push_back(16'h8100);
      for (int k = 0; k < 256; k++) exp_mosi.push_back(16'h0000);
      sq.push_back(16'h0000); sq.push_back(16'hFFFF);
      for (int k = 1; k <= 255; k++) begin
         v = 16'(k * 37 + 3);
         sq.push_back(v);
         exp_rdata.push_back(v);
      end
      issue(1, 0, 0, 13'h0100, 8'd255, 257 * 16 + 1, 0, 255);
      wait_idle("read255");

      // sck timing at CLKDIV 1 and 5.
      rd = 1'b0; wr = 1'b1; autoinc = 1'b0; addr = '0; count = '0;
      tiss[1]++; tiss[2]++;
      @(negedge clock); start_t = 1'b1;
      @(negedge clock); start_t = 1'b0;
      begin
         int n = 0;
         repeat (3) @(negedge clock);
         while ((t_busy[1] || t_busy[2]) && n < 2000) begin @(negedge clock); n++; end
         if (t_busy[1] || t_busy[2]) begin
            checks++; errors++;
            $display("FAIL timing frames: busy still high after %0d cycles", n);
         end
      end
      repeat (5) @(negedge clock);

      chk("mosi queue drained", exp_mosi.size(), 0);
      chk("rdata queue drained", exp_rdata.size(), 0);
      chk("frame queue drained", exp_frame.size(), 0);
      chk("cs frames", frames_seen, frames_exp);
      for (int i = 0; i < 3; i++) chk($sformatf("timed frames %0d", i), tdone[i], tiss[i]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
